// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART deframer with output FIFO.
//   PAR_NONE / PAR_ODD / PAR_EVEN : parity_type encodings (2'b11 also = none)
//   IDLE_BIT                      : value replicated onto raw_data when empty
//   cap_state_t                   : capture stage FSM states
//   stop_offset()                 : bit index of the first stop bit in a frame
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_ODD  = 2'b01;
   localparam logic [1:0] PAR_EVEN = 2'b10;

   localparam logic IDLE_BIT = 1'b1;

   typedef enum logic {S_IDLE, S_HELD} cap_state_t;

   // Frame layout is start, data, [parity], stop(s), LSB first.
   function automatic int stop_offset(input int data_width, input logic par_en);
      return data_width + 1 + (par_en ? 1 : 0);
   endfunction

endpackage

// File: rtl/deframe_fifo.sv
// ---------------------------------------------------------------------------
// deframe_fifo
// Generic synchronous FIFO, WIDTH bits x DEPTH entries (DEPTH power of two).
// Ports:
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   i_push, i_wdata: write request and data (ignored when full unless a pop
//                    happens in the same cycle)
//   i_pop          : read request (ignored when empty)
//   o_rdata        : head entry (combinational read of the head slot)
//   o_full, o_empty: status flags
//   o_level        : number of entries held
// ---------------------------------------------------------------------------
module deframe_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [LVL_W-1:0] o_level
);

   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full  = (r_level == FULL_LVL);
   assign o_empty = (r_level == '0);
   assign o_level = r_level;
   assign o_rdata = r_mem[r_rd_ptr];

   assign w_do_pop  = i_pop & ~o_empty;
   // A pop frees the slot in the same cycle, so a full FIFO still accepts.
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked by the pointers/level.
   always_ff @(posedge clock) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/uart_deframe_fifo.sv
// ---------------------------------------------------------------------------
// uart_deframe_fifo
// Registered UART deframer: captures a frame on the rising edge of
// recieved_flag, splits it into start/data/parity/stop, checks parity and
// framing, and buffers {data, parity_error, frame_error} in a DEPTH-entry
// FIFO drained through a valid/ready handshake.
// Optional feature macro: UART_DEFRAME_ERR_COUNT_EN (saturating err_count).
// Ports:
//   clock, reset_n   : rising-edge clock, asynchronous active-low reset
//   recieved_flag    : frame-ready level; 0->1 edge captures data_parll
//   data_parll       : frame, LSB first: start, data, [parity], stop(s)
//   parity_type      : 00/11 none, 01 odd, 10 even
//   err_clear        : pulse, clears overrun and err_count
//   out_ready        : consumer accepts head entry
//   out_valid        : head entry valid
//   raw_data         : head data (all ones when empty)
//   parity_error     : head parity mismatch (0 when empty)
//   frame_error      : head framing error (0 when empty)
//   overrun          : sticky, a frame was dropped on a full FIFO
//   fill_level       : entries held
//   err_count        : error counter (0 when the feature is disabled)
// ---------------------------------------------------------------------------
module uart_deframe_fifo
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int STOP_BITS  = 1,
   parameter int DEPTH      = 4,
   localparam int FRAME_W   = 2 + DATA_WIDTH + STOP_BITS,
   localparam int LVL_W     = $clog2(DEPTH) + 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  recieved_flag,
   input  logic [FRAME_W-1:0]    data_parll,
   input  logic [1:0]            parity_type,
   input  logic                  err_clear,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] raw_data,
   output logic                  parity_error,
   output logic                  frame_error,
   output logic                  overrun,
   output logic [LVL_W-1:0]      fill_level,
   output logic [15:0]           err_count
);

   localparam int OFF_PAR   = stop_offset(DATA_WIDTH, 1'b1);
   localparam int OFF_NOPAR = stop_offset(DATA_WIDTH, 1'b0);
   localparam int ENTRY_W   = DATA_WIDTH + 2;

   logic                  r_flag_d;
   logic                  w_capture;
   logic [DATA_WIDTH-1:0] w_data;
   logic                  w_par_en;
   logic [STOP_BITS-1:0]  w_stops;
   logic                  w_perr;
   logic                  w_ferr;

   cap_state_t            r_state;
   logic [DATA_WIDTH-1:0] r_stage_data;
   logic                  r_stage_perr;
   logic                  r_stage_ferr;

   logic                  w_push;
   logic                  w_full;
   logic                  w_empty;
   logic [ENTRY_W-1:0]    w_head;
   logic [LVL_W-1:0]      w_level;
   logic                  w_drop;
   logic                  w_wr_ok;
   logic                  r_overrun;

   // ---- edge detect and field checks ----
   assign w_capture = recieved_flag & ~r_flag_d;
   assign w_data    = data_parll[DATA_WIDTH:1];
   assign w_par_en  = (parity_type == PAR_ODD) || (parity_type == PAR_EVEN);
   // Without parity the stop field slides down one bit; the top bit is unused.
   assign w_stops   = w_par_en ? data_parll[OFF_PAR +: STOP_BITS]
                               : data_parll[OFF_NOPAR +: STOP_BITS];
   assign w_ferr    = data_parll[0] | ~(&w_stops);

   always_comb begin
      w_perr = 1'b0;
      case (parity_type)
         PAR_ODD:  w_perr = ~(^{w_data, data_parll[DATA_WIDTH+1]});
         PAR_EVEN: w_perr = ^{w_data, data_parll[DATA_WIDTH+1]};
         PAR_NONE: w_perr = 1'b0;
         default:  w_perr = 1'b0;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_flag_d <= 1'b0;
      else          r_flag_d <= recieved_flag;
   end

   // ---- capture stage ----
   // HELD always pushes on the next edge; a new capture in that same cycle
   // reloads the stage so back-to-back frames are never lost here.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_stage_data <= '0;
         r_stage_perr <= 1'b0;
         r_stage_ferr <= 1'b0;
      end else begin
         if (w_capture) begin
            r_state      <= S_HELD;
            r_stage_data <= w_data;
            r_stage_perr <= w_perr;
            r_stage_ferr <= w_ferr;
         end else if (r_state == S_HELD) begin
            r_state <= S_IDLE;
         end
      end
   end

   assign w_push = (r_state == S_HELD);

   // ---- output FIFO ----
   deframe_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_wdata ({r_stage_data, r_stage_perr, r_stage_ferr}),
      .i_pop   (out_ready),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   // Full implies non-empty, so out_ready alone means a pop will happen.
   assign w_drop  = w_push & w_full & ~out_ready;
   assign w_wr_ok = w_push & ~w_drop;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)       r_overrun <= 1'b0;
      else if (w_drop)    r_overrun <= 1'b1;
      else if (err_clear) r_overrun <= 1'b0;
   end

   assign out_valid    = ~w_empty;
   assign raw_data     = w_empty ? {DATA_WIDTH{IDLE_BIT}} : w_head[ENTRY_W-1:2];
   assign parity_error = ~w_empty & w_head[1];
   assign frame_error  = ~w_empty & w_head[0];
   assign overrun      = r_overrun;
   assign fill_level   = w_level;

`ifdef UART_DEFRAME_ERR_COUNT_EN
   logic        w_err_inc;
   logic [15:0] r_err_count;

   assign w_err_inc = (w_wr_ok & (r_stage_perr | r_stage_ferr)) | w_drop;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_err_count <= 16'd0;
      end else if (err_clear) begin
         r_err_count <= {15'd0, w_err_inc};
      end else if (w_err_inc && (r_err_count != 16'hFFFF)) begin
         r_err_count <= r_err_count + 16'd1;
      end
   end

   assign err_count = r_err_count;
`else
   assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_uart_deframe_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_deframe_fifo
// Directed bench for uart_deframe_fifo (DATA_WIDTH=8, STOP_BITS=1, DEPTH=4).
// Frames are built as {stop, parity_or_stop, data[7:0], start}.
// ---------------------------------------------------------------------------
module tb_uart_deframe_fifo;

   logic        clock;
   logic        reset_n;
   logic        recieved_flag;
   logic [10:0] data_parll;
   logic [1:0]  parity_type;
   logic        err_clear;
   logic        out_ready;
   logic        out_valid;
   logic [7:0]  raw_data;
   logic        parity_error;
   logic        frame_error;
   logic        overrun;
   logic [2:0]  fill_level;
   logic [15:0] err_count;

   int checks = 0;
   int errors = 0;

`ifdef UART_DEFRAME_ERR_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   uart_deframe_fifo #(
      .DATA_WIDTH (8),
      .STOP_BITS  (1),
      .DEPTH      (4)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .recieved_flag (recieved_flag),
      .data_parll    (data_parll),
      .parity_type   (parity_type),
      .err_clear     (err_clear),
      .out_ready     (out_ready),
      .out_valid     (out_valid),
      .raw_data      (raw_data),
      .parity_error  (parity_error),
      .frame_error   (frame_error),
      .overrun       (overrun),
      .fill_level    (fill_level),
      .err_count     (err_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         end
   endtask

   function automatic logic [10:0] fr(input logic top, input logic mid,
                                      input logic [7:0] d, input logic start);
      return {top, mid, d, start};
   endfunction

   // Raise the flag for one cycle, then low; the entry lands after 2 edges.
   task automatic send(input logic [10:0] f, input logic [1:0] pt);
      data_parll    = f;
      parity_type   = pt;
      recieved_flag = 1'b1;
      step();
      recieved_flag = 1'b0;
      step();
   endtask

   task automatic pop();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   function automatic logic [15:0] ec(input int n);
      return CNT_EN ? 16'(n) : 16'd0;
   endfunction

   initial begin
      reset_n       = 1'b0;
      recieved_flag = 1'b0;
      data_parll    = '0;
      parity_type   = 2'b00;
      err_clear     = 1'b0;
      out_ready     = 1'b0;
      #1;
      chk("rst_valid",   out_valid,    1'b0);
      chk("rst_raw",     raw_data,     8'hFF);
      chk("rst_perr",    parity_error, 1'b0);
      chk("rst_ferr",    frame_error,  1'b0);
      chk("rst_overrun", overrun,      1'b0);
      chk("rst_fill",    fill_level,   3'd0);
      chk("rst_errcnt",  err_count,    16'd0);
      step();
      step();
      reset_n = 1'b1;
      step();

      // even parity, good frame; check latency edge by edge
      data_parll    = 11'b1_0_10100101_0;
      parity_type   = 2'b10;
      recieved_flag = 1'b1;
      step();
      recieved_flag = 1'b0;
      chk("lat1_valid", out_valid, 1'b0);
      step();
      chk("even_valid", out_valid,    1'b1);
      chk("even_raw",   raw_data,     8'hA5);
      chk("even_perr",  parity_error, 1'b0);
      chk("even_ferr",  frame_error,  1'b0);
      chk("even_fill",  fill_level,   3'd1);
      pop();
      chk("pop_empty_valid", out_valid, 1'b0);
      chk("pop_empty_raw",   raw_data,  8'hFF);
      pop();
      chk("pop_when_empty_fill", fill_level, 3'd0);

      // odd parity on the same frame -> parity error (err 1)
      send(11'b1_0_10100101_0, 2'b01);
      chk("odd_perr", parity_error, 1'b1);
      chk("odd_ferr", frame_error,  1'b0);
      pop();

      // stop bit 0 -> frame error (err 2)
      send(fr(1'b0, 1'b0, 8'hA5, 1'b0), 2'b10);
      chk("stop0_ferr", frame_error,  1'b1);
      chk("stop0_perr", parity_error, 1'b0);
      pop();

      // parity none: stop at bit 9, top bit ignored
      send(fr(1'b0, 1'b1, 8'h3C, 1'b0), 2'b00);
      chk("none_raw",  raw_data,     8'h3C);
      chk("none_perr", parity_error, 1'b0);
      chk("none_ferr", frame_error,  1'b0);
      pop();
      // parity_type 11 is also none; bit 9 = 0 is a bad stop (err 3)
      send(fr(1'b1, 1'b0, 8'h3C, 1'b0), 2'b11);
      chk("none11_ferr", frame_error,  1'b1);
      chk("none11_perr", parity_error, 1'b0);
      pop();

      // flag held high for 5 cycles -> exactly one entry
      data_parll    = fr(1'b1, 1'b1, 8'h5A, 1'b0);
      parity_type   = 2'b00;
      recieved_flag = 1'b1;
      for (int i = 0; i < 5; i++) step();
      recieved_flag = 1'b0;
      step();
      chk("hold_fill", fill_level, 3'd1);
      chk("hold_raw",  raw_data,   8'h5A);
      pop();
      chk("hold_fill_after_pop", fill_level, 3'd0);
      chk("errcnt_3", err_count, ec(3));

      // overflow: 5 frames into a 4-deep FIFO, 5th dropped (err 4)
      send(fr(1'b1, 1'b1, 8'h11, 1'b0), 2'b00);
      send(fr(1'b1, 1'b1, 8'h22, 1'b0), 2'b00);
      send(fr(1'b1, 1'b1, 8'h33, 1'b0), 2'b00);
      send(fr(1'b1, 1'b1, 8'h44, 1'b0), 2'b00);
      chk("full_overrun_pre", overrun, 1'b0);
      send(fr(1'b1, 1'b1, 8'h55, 1'b0), 2'b00);
      chk("ovf_fill",    fill_level, 3'd4);
      chk("ovf_overrun", overrun,    1'b1);
      chk("ovf_errcnt",  err_count,  ec(4));
      err_clear = 1'b1;
      step();
      err_clear = 1'b0;
      chk("clr_overrun", overrun,   1'b0);
      chk("clr_errcnt",  err_count, 16'd0);
      chk("ovf_head0", raw_data, 8'h11); pop();
      chk("ovf_head1", raw_data, 8'h22); pop();
      chk("ovf_head2", raw_data, 8'h33); pop();
      chk("ovf_head3", raw_data, 8'h44); pop();
      chk("ovf_drained", out_valid, 1'b0);

      // full FIFO, push and pop in the same cycle
      send(fr(1'b1, 1'b1, 8'hA1, 1'b0), 2'b00);
      send(fr(1'b1, 1'b1, 8'hA2, 1'b0), 2'b00);
      send(fr(1'b1, 1'b1, 8'hA3, 1'b0), 2'b00);
      send(fr(1'b1, 1'b1, 8'hA4, 1'b0), 2'b00);
      data_parll    = fr(1'b1, 1'b1, 8'hB5, 1'b0);
      recieved_flag = 1'b1;
      step();
      recieved_flag = 1'b0;
      out_ready     = 1'b1;
      step();
      out_ready     = 1'b0;
      chk("pp_fill",    fill_level, 3'd4);
      chk("pp_overrun", overrun,    1'b0);
      chk("pp_head0", raw_data, 8'hA2); pop();
      chk("pp_head1", raw_data, 8'hA3); pop();
      chk("pp_head2", raw_data, 8'hA4); pop();
      chk("pp_head3", raw_data, 8'hB5); pop();
      chk("pp_drained", fill_level, 3'd0);

      // 2 bad frames + 2 good + 1 dropped -> 3 error events
      send(fr(1'b0, 1'b0, 8'hC1, 1'b0), 2'b00);
      send(fr(1'b1, 1'b1, 8'hC2, 1'b1), 2'b00);
      send(fr(1'b1, 1'b1, 8'hC3, 1'b0), 2'b00);
      send(fr(1'b1, 1'b1, 8'hC4, 1'b0), 2'b00);
      send(fr(1'b1, 1'b1, 8'hC5, 1'b0), 2'b00);
      chk("cnt_errcnt",  err_count, ec(3));
      chk("cnt_overrun", overrun,   1'b1);
      chk("cnt_head_ferr", frame_error, 1'b1);
      pop();
      chk("cnt_fill3", fill_level, 3'd3);

      // asynchronous reset mid-stream with 3 entries buffered
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid",   out_valid,  1'b0);
      chk("mid_rst_fill",    fill_level, 3'd0);
      chk("mid_rst_raw",     raw_data,   8'hFF);
      chk("mid_rst_overrun", overrun,    1'b0);
      chk("mid_rst_errcnt",  err_count,  16'd0);
      step();
      reset_n = 1'b1;
      step();
      chk("post_rst_valid", out_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
